// File: rtl/logit_result_reader.sv
// logit_result_reader: captures a logit vector, runs a sequential signed argmax and,
// when LOGIT_STREAM_EN is defined, streams the raw logits out over valid/ready.
module logit_result_reader #(
    parameter int NUM_CLASSES = 10,
    parameter int ACC_WIDTH   = 32,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_data [NUM_CLASSES-1:0],
    output logic                        busy,
    output logic                        class_valid,
    output logic [IDX_WIDTH-1:0]        class_idx,
    output logic signed [ACC_WIDTH-1:0] class_score,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]        out_index,
    output logic                        out_last,
    output logic                        overrun,
    input  logic                        clear_overrun,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] buffer [NUM_CLASSES-1:0];
    logic signed [ACC_WIDTH-1:0] max_val;
    logic [IDX_WIDTH-1:0]        max_idx;
    logic [IDX_WIDTH-1:0]        ptr;
    logic signed [ACC_WIDTH-1:0] scan_elem;
    logic                        scan_gt;
    logic                        final_hs;
    logic                        accept;
    logic                        drop;

    assign scan_elem = buffer[ptr];
    // Strict greater-than keeps the lowest index on ties.
    assign scan_gt   = scan_elem > max_val;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Stream handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_index/out_last hold.
`ifdef LOGIT_STREAM_EN
    assign final_hs = (state == SEND) && out_valid && out_ready && out_last;
`else
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign final_hs  = 1'b0;
    assign out_valid = 1'b0;
    assign out_data  = '0;
    assign out_index = '0;
    assign out_last  = 1'b0;
`endif

    assign accept = in_valid && ((state == IDLE) || final_hs);
    assign drop   = in_valid && !accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            max_val     <= '0;
            max_idx     <= '0;
            ptr         <= '0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            overrun     <= 1'b0;
`ifdef LOGIT_STREAM_EN
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
`endif
        end else begin
            class_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_gt) begin
                        max_val <= scan_elem;
                        max_idx <= ptr;
                    end
                    if (ptr == LAST_IDX) begin
                        class_valid <= 1'b1;
                        class_idx   <= scan_gt ? ptr : max_idx;
                        class_score <= scan_gt ? scan_elem : max_val;
`ifdef LOGIT_STREAM_EN
                        state       <= SEND;
                        out_valid   <= 1'b1;
                        out_data    <= buffer[0];
                        out_index   <= '0;
                        out_last    <= 1'b0;
`else
                        state       <= IDLE;
`endif
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
`ifdef LOGIT_STREAM_EN
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_data  <= buffer[out_index + 1'b1];
                            out_index <= out_index + 1'b1;
                            out_last  <= ((out_index + 1'b1) == LAST_IDX);
                        end
                    end
                end
`endif
                default: ;
            endcase

            // Capture overrides the state update above so the final-handshake
            // overlap goes straight back to SCAN.
            if (accept) begin
                buffer  <= in_data;
                max_val <= in_data[0];
                max_idx <= '0;
                ptr     <= IDX_WIDTH'(1);
                state   <= SCAN;
            end

            if (clear_overrun) overrun <= 1'b0;
            if (drop)          overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_logit_result_reader.sv
// Directed table-driven bench for logit_result_reader; stream checks are active
// only when LOGIT_STREAM_EN is defined.
module tb_logit_result_reader;

    localparam int NC = 10;
    localparam int AW = 32;
    localparam int IW = 4;

    typedef logic signed [AW-1:0] vec_t [0:NC-1];
    typedef struct {
        vec_t              v;
        int                exp_idx;
        logic [AW-1:0]     exp_score;
    } vec_rec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 clear_overrun = 1'b0;
    logic signed [AW-1:0] in_data [NC-1:0];
    logic                 busy, class_valid, out_valid, out_last, overrun;
    logic [IW-1:0]        class_idx, out_index;
    logic signed [AW-1:0] class_score, out_data;
    logic [1:0]           dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW-1:0] exp_q [$];
    vec_rec_t tbl [6];

    logit_result_reader #(.NUM_CLASSES(NC), .ACC_WIDTH(AW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .class_valid(class_valid), .class_idx(class_idx),
        .class_score(class_score), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .overrun(overrun), .clear_overrun(clear_overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input vec_t v);
        for (int i = 0; i < NC; i++) in_data[i] = v[i];
    endtask

    task automatic start_vec(input vec_t v);
        in_valid = 1'b1;
        set_data(v);
        step();
        in_valid = 1'b0;
    endtask

    // Waits for class_valid; start is the cycle offset from the capture cycle.
    task automatic wait_class(input string name, input int start, input vec_rec_t r);
        int cnt;
        cnt = start;
        while (!class_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check({name, " latency"}, cnt, NC);
        check({name, " class_idx"}, class_idx, r.exp_idx);
        check({name, " class_score"}, class_score, r.exp_score);
`ifdef LOGIT_STREAM_EN
        check({name, " out_valid with class"}, out_valid, 1'b1);
`else
        check({name, " out_valid tied"}, out_valid, 1'b0);
`endif
    endtask

`ifdef LOGIT_STREAM_EN
    task automatic drain(input string name, input vec_t v, input int stall_beat,
                         input int drop_beat, input bit ovl, input vec_t nv);
        int beats;
        int guard;
        beats = 0;
        guard = 0;
        exp_q.delete();
        for (int i = 0; i < NC; i++) exp_q.push_back(v[i]);
        out_ready = 1'b1;
        while (beats < NC && guard < 100) begin
            guard++;
            if (out_valid) begin
                if (beats == stall_beat) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        step();
                        check({name, " stall valid"}, out_valid, 1'b1);
                        check({name, " stall data"}, out_data, v[stall_beat]);
                        check({name, " stall index"}, out_index, stall_beat);
                    end
                    out_ready = 1'b1;
                end
                check({name, " beat data"}, out_data, exp_q.pop_front());
                check({name, " beat index"}, out_index, beats);
                check({name, " beat last"}, out_last, beats == NC - 1);
                if (beats == drop_beat || (ovl && beats == NC - 1)) begin
                    in_valid = 1'b1;
                    set_data(nv);
                end
                step();
                in_valid = 1'b0;
                beats++;
                if (beats == 1) check({name, " class pulse"}, class_valid, 1'b0);
            end else begin
                step();
            end
        end
        check({name, " handshakes"}, beats, NC);
        check({name, " out_valid after last"}, out_valid, 1'b0);
        check({name, " busy after last"}, busy, ovl);
    endtask
`endif

    task automatic finish_vec(input string name, input vec_t v, input int stall_beat);
`ifdef LOGIT_STREAM_EN
        drain(name, v, stall_beat, -1, 1'b0, v);
`else
        step();
        check({name, " class pulse"}, class_valid, 1'b0);
        check({name, " busy after"}, busy, 1'b0);
`endif
    endtask

    initial begin
        int guard;
        tbl[0] = '{'{-5, 300, 12, 0, -1, 7, 299, 3, 2, 1}, 1, 32'd300};
        tbl[1] = '{'{0, 0, 0, 1000, 0, 0, 0, 1000, 0, 0}, 3, 32'd1000};
        tbl[2] = '{'{-1, -2, -3, -4, -5, -6, -7, -8, -9, 32'sh80000000}, 0, 32'hFFFF_FFFF};
        tbl[3] = '{'{5, 5, 5, 5, 5, 5, 5, 5, 5, 5}, 0, 32'd5};
        tbl[4] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'sh7FFFFFFF}, 9, 32'h7FFF_FFFF};
        tbl[5] = '{'{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
                     32'sh80000000, 32'sh80000001, 32'sh80000000, 32'sh80000000,
                     32'sh80000000, 32'sh80000000}, 5, 32'h8000_0001};
        set_data(tbl[0].v);

        repeat (3) step();
        check("reset busy", busy, 1'b0);
        check("reset class_valid", class_valid, 1'b0);
        check("reset class_idx", class_idx, 0);
        check("reset class_score", class_score, 0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_last", out_last, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            start_vec(tbl[i].v);
            check($sformatf("vec%0d busy", i), busy, 1'b1);
            wait_class($sformatf("vec%0d", i), 1, tbl[i]);
            finish_vec($sformatf("vec%0d", i), tbl[i].v, (i == 0) ? 4 : -1);
            check($sformatf("vec%0d no overrun", i), overrun, 1'b0);
        end

        // Dropped vector: stream/result of the first vector must be unaffected.
        start_vec(tbl[1].v);
`ifdef LOGIT_STREAM_EN
        wait_class("drop", 1, tbl[1]);
        drain("drop", tbl[1].v, -1, 2, 1'b0, tbl[0].v);
`else
        start_vec(tbl[0].v);
        check("drop overrun set", overrun, 1'b1);
        wait_class("drop", 2, tbl[1]);
        step();
`endif
        check("overrun sticky", overrun, 1'b1);
        step();
        check("overrun sticky 2", overrun, 1'b1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("overrun cleared", overrun, 1'b0);

        // Clear and drop in the same cycle: set wins.
        start_vec(tbl[2].v);
        clear_overrun = 1'b1;
        start_vec(tbl[0].v);
        clear_overrun = 1'b0;
        check("clear+drop overrun", overrun, 1'b1);
        wait_class("clear+drop", 2, tbl[2]);
        finish_vec("clear+drop", tbl[2].v, -1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("overrun cleared 2", overrun, 1'b0);

        // Back-to-back acceptance: final-handshake overlap, or IDLE right after result.
        start_vec(tbl[3].v);
        wait_class("overlap first", 1, tbl[3]);
`ifdef LOGIT_STREAM_EN
        drain("overlap first", tbl[3].v, -1, -1, 1'b1, tbl[4].v);
`else
        start_vec(tbl[4].v);
`endif
        check("overlap no overrun", overrun, 1'b0);
        wait_class("overlap second", 1, tbl[4]);
        finish_vec("overlap second", tbl[4].v, -1);

        // Reset mid-run, with a pending overrun that reset must clear.
        start_vec(tbl[0].v);
        start_vec(tbl[1].v);
        check("pre-reset overrun", overrun, 1'b1);
`ifdef LOGIT_STREAM_EN
        out_ready = 1'b1;
        guard = 0;
        while (!(out_valid && out_index == 4'd5) && guard < 40) begin
            step();
            guard++;
        end
        check("reach beat 5", out_index, 5);
`else
        step();
        step();
        check("mid-scan busy", busy, 1'b1);
`endif
        rst_n = 1'b0;
        step();
        check("mid reset busy", busy, 1'b0);
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset class_valid", class_valid, 1'b0);
        check("mid reset overrun", overrun, 1'b0);
        rst_n = 1'b1;
        step();
        start_vec(tbl[5].v);
        wait_class("after reset", 1, tbl[5]);
        finish_vec("after reset", tbl[5].v, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
